// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: the pipeline M-stage
// and a debug/loader port share the RAM. Round-robin between the two, with a
// debug lock mode that is bounded by MAX_HOLD while the pipeline is waiting.
module dmem_arbiter #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  // pipeline port
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_stall,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  // debug / loader port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // RAM command
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAST_P = 2'd1,
    LAST_D = 2'd2,
    LOCK_D = 2'd3
  } state_e;

  state_e          state_q;
  logic [HW-1:0]   hold_cnt_q;
  logic            p_tag_q;
  logic            d_tag_q;
  logic [DW-1:0]   p_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic            p_gnt_c;
  logic            d_gnt_c;
  logic [HW-1:0]   hold_nx_c;

  // Grant decision for the current cycle; IDLE and an expired lock behave as LAST_D
  always_comb begin
    p_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (reset) begin
      if (state_q == LOCK_D && d_req && d_lock) begin
        d_gnt_c = 1'b1;
      end else if (p_req && d_req) begin
        if (state_q == LAST_P) d_gnt_c = 1'b1;
        else                   p_gnt_c = 1'b1;
      end else if (p_req) begin
        p_gnt_c = 1'b1;
      end else if (d_req) begin
        d_gnt_c = 1'b1;
      end
    end
  end

  // Locked-grant counter value after this cycle, saturating at MAX_HOLD
  always_comb begin
    hold_nx_c = hold_cnt_q;
    if (p_req && hold_cnt_q < HW'(MAX_HOLD)) hold_nx_c = hold_cnt_q + HW'(1);
  end

  // RAM command mux driven by the winner; all zero when nobody is granted
  always_comb begin
    ram_en    = p_gnt_c | d_gnt_c;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (d_gnt_c) begin
      ram_we    = d_we;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end else if (p_gnt_c) begin
      ram_we    = p_we;
      ram_addr  = p_addr;
      ram_wdata = p_wdata;
    end
  end

  // Port-facing status and read return; forced to zero while in reset
  always_comb begin
    p_stall  = reset & p_req & ~p_gnt_c;
    d_gnt    = d_gnt_c;
    p_rvalid = reset & p_tag_q;
    d_rvalid = reset & d_tag_q;
    p_rdata  = '0;
    d_rdata  = '0;
    if (reset) begin
      p_rdata = p_tag_q ? ram_rdata : p_rdata_q;
      d_rdata = d_tag_q ? ram_rdata : d_rdata_q;
    end
  end

  // Arbitration state, lock hold counter, read tags and read-data hold registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      p_tag_q    <= 1'b0;
      d_tag_q    <= 1'b0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      p_tag_q <= p_gnt_c & ~p_we;
      d_tag_q <= d_gnt_c & ~d_we;
      if (p_tag_q) p_rdata_q <= ram_rdata;
      if (d_tag_q) d_rdata_q <= ram_rdata;

      if (p_gnt_c) begin
        state_q    <= LAST_P;
        hold_cnt_q <= '0;
      end else if (d_gnt_c) begin
        if (d_lock && !(p_req && hold_nx_c >= HW'(MAX_HOLD))) begin
          state_q    <= LOCK_D;
          hold_cnt_q <= hold_nx_c;
        end else begin
          // unlocked grant, or the waiting pipeline has used up the hold budget
          state_q    <= LAST_D;
          hold_cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, per-port read
// scoreboards, and one task per scenario.
module tb_dmem_arbiter;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_req, p_we, p_stall, p_rvalid;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t p_q[$];
  exp_t d_q[$];
  exp_t pe, de;

  logic [DW-1:0] mem [32];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | DW'(i));
  endfunction

  // Behavioural single-port RAM, reloaded with known contents during reset
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Read-return scoreboards: every rvalid must match the next expected entry on its due cycle
  always @(negedge clk) begin
    if (p_rvalid) begin
      checks++;
      if (p_q.size() == 0) begin
        errors++;
        $display("FAIL p_rvalid_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        pe = p_q.pop_front();
        if (p_rdata !== pe.data || cyc != pe.due) begin
          errors++;
          $display("FAIL p_read_return cyc=%0d got=%h want=%h due=%0d", cyc, p_rdata, pe.data, pe.due);
        end
      end
    end else if (p_q.size() > 0 && p_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL p_rvalid_missing cyc=%0d got=0 want=1", cyc);
      void'(p_q.pop_front());
    end
    if (d_rvalid) begin
      checks++;
      if (d_q.size() == 0) begin
        errors++;
        $display("FAIL d_rvalid_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        de = d_q.pop_front();
        if (d_rdata !== de.data || cyc != de.due) begin
          errors++;
          $display("FAIL d_read_return cyc=%0d got=%h want=%h due=%0d", cyc, d_rdata, de.data, de.due);
        end
      end
    end else if (d_q.size() > 0 && d_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL d_rvalid_missing cyc=%0d got=0 want=1", cyc);
      void'(d_q.pop_front());
    end
  end

  task automatic idle_inputs;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic push_p(input logic [DW-1:0] data);
    pe.data = data; pe.due = cyc + 1; p_q.push_back(pe);
  endtask

  task automatic push_d(input logic [DW-1:0] data);
    de.data = data; de.due = cyc + 1; d_q.push_back(de);
  endtask

  // Reset held with both ports requesting: every output must read zero
  task automatic test_reset;
    reset = 0;
    p_req = 1; p_we = 0; p_addr = 5'd3;
    d_req = 1; d_we = 0; d_addr = 5'd4; d_lock = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({p_stall, d_gnt, ram_en, ram_we, p_rvalid, d_rvalid} !== 6'b0 ||
          p_rdata !== '0 || d_rdata !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%b/%h/%h want=0", {p_stall, d_gnt, ram_en, ram_we, p_rvalid, d_rvalid}, p_rdata, d_rdata);
      end
      next_cycle();
    end
    idle_inputs();
    reset = 1;
  endtask

  // Contention from IDLE: P, D, P
  task automatic test_round_robin;
    logic          exp_p [3];
    logic [AW-1:0] exp_a;
    exp_p[0] = 1; exp_p[1] = 0; exp_p[2] = 1;
    p_req = 1; p_we = 0; p_addr = 5'd1;
    d_req = 1; d_we = 0; d_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_a = exp_p[i] ? 5'd1 : 5'd2;
      checks++;
      if (p_stall !== !exp_p[i] || d_gnt !== !exp_p[i] || ram_addr !== exp_a || ram_en !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant step=%0d got stall=%b gnt=%b addr=%0d want stall=%b gnt=%b addr=%0d",
                 i, p_stall, d_gnt, ram_addr, !exp_p[i], !exp_p[i], exp_a);
      end
      if (exp_p[i]) push_p(init_val(1));
      else          push_d(init_val(2));
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  // Pipeline-only load of address 5, then read data held while rvalid is low
  task automatic test_p_only;
    p_req = 1; p_we = 0; p_addr = 5'd5;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 5'd5 || p_stall !== 1'b0) begin
      errors++;
      $display("FAIL p_only_cmd got en=%b we=%b addr=%0d stall=%b want en=1 we=0 addr=5 stall=0", ram_en, ram_we, ram_addr, p_stall);
    end
    push_p(32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    checks++;
    if (p_rvalid !== 1'b0 || p_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL p_rdata_hold got v=%b d=%h want v=0 d=deadbeef", p_rvalid, p_rdata);
    end
    next_cycle();
  endtask

  // Locked debug traffic against a waiting pipeline: 4 D, 1 P, relock
  task automatic test_lock;
    logic exp_d [10];
    for (int i = 0; i < 10; i++) exp_d[i] = !(i == 4 || i == 9);
    p_req = 1; p_we = 1; p_addr = 5'd10; p_wdata = 32'h0000_1010;
    d_req = 1; d_we = 1; d_addr = 5'd11; d_wdata = 32'h0000_1111; d_lock = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (d_gnt !== exp_d[i] || p_stall !== exp_d[i] || ram_we !== 1'b1 ||
          ram_addr !== (exp_d[i] ? 5'd11 : 5'd10)) begin
        errors++;
        $display("FAIL lock_grant step=%0d got gnt=%b stall=%b addr=%0d want gnt=%b stall=%b",
                 i, d_gnt, p_stall, ram_addr, exp_d[i], exp_d[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Debug writes address 31, pipeline reads it back; debug never sees rvalid
  task automatic test_write_read;
    d_req = 1; d_we = 1; d_addr = 5'd31; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'd31 || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_cmd got gnt=%b we=%b addr=%0d wd=%h want gnt=1 we=1 addr=31 wd=12345678", d_gnt, ram_we, ram_addr, ram_wdata);
    end
    next_cycle();
    idle_inputs();
    p_req = 1; p_we = 0; p_addr = 5'd31;
    @(negedge clk);
    checks++;
    if (p_stall !== 1'b0 || ram_we !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_cmd got stall=%b we=%b d_rvalid=%b want 0/0/0", p_stall, ram_we, d_rvalid);
    end
    push_p(32'h12345678);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_d_rvalid got=%b want=0", d_rvalid);
    end
    next_cycle();
  endtask

  // Ten idle cycles after a pipeline grant: RAM quiet and LAST_P kept
  task automatic test_idle;
    p_req = 1; p_we = 1; p_addr = 5'd20; p_wdata = 32'h2020_2020;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0 || p_stall !== 1'b0 || d_gnt !== 1'b0) begin
        errors++;
        $display("FAIL idle step=%0d got en=%b stall=%b gnt=%b want 0/0/0", i, ram_en, p_stall, d_gnt);
      end
      next_cycle();
    end
    p_req = 1; p_we = 1; p_addr = 5'd21;
    d_req = 1; d_we = 1; d_addr = 5'd22;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || p_stall !== 1'b1) begin
      errors++;
      $display("FAIL idle_state_held got gnt=%b stall=%b want gnt=1 stall=1", d_gnt, p_stall);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Reset lands right after a granted read: no rvalid, rdata cleared, P wins first after release
  task automatic test_reset_mid_read;
    p_req = 1; p_we = 0; p_addr = 5'd7;
    @(negedge clk);
    checks++;
    if (p_stall !== 1'b0 || ram_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_rd_grant got stall=%b en=%b want 0/1", p_stall, ram_en);
    end
    next_cycle();
    idle_inputs();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (p_rvalid !== 1'b0 || p_rdata !== '0 || d_rdata !== '0) begin
        errors++;
        $display("FAIL rst_mid_read step=%0d got v=%b pd=%h dd=%h want 0/0/0", i, p_rvalid, p_rdata, d_rdata);
      end
      next_cycle();
    end
    reset = 1;
    p_req = 1; p_we = 0; p_addr = 5'd8;
    d_req = 1; d_we = 0; d_addr = 5'd9;
    @(negedge clk);
    checks++;
    if (p_stall !== 1'b0 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_contention got stall=%b gnt=%b want 0/0", p_stall, d_gnt);
    end
    push_p(init_val(8));
    next_cycle();
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || p_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_second_contention got gnt=%b stall=%b want 1/1", d_gnt, p_stall);
    end
    push_d(init_val(9));
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_p_only();
    test_lock();
    test_write_read();
    test_idle();
    test_reset_mid_read();
    checks++;
    if (p_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got p=%0d d=%0d want 0/0", p_q.size(), d_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 5, RAM word-address width (32 words).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive locked grants to the debug port while the pipeline waits.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 p_req  in  1  pipeline M-stage access request.
REQ-007 p_we  in  1  pipeline write enable (1 = store, 0 = load).
REQ-008 p_addr  in  AW  pipeline word address.
REQ-009 p_wdata  in  DW  pipeline store data.
REQ-010 p_stall  out  1  p_req asserted and not granted this cycle.
REQ-011 p_rvalid  out  1  pipeline read data valid.
REQ-012 p_rdata  out  DW  pipeline read data.
REQ-013 d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug/loader port, same meaning as p_*.
REQ-014 d_lock  in  1  debug port requests exclusive back-to-back ownership.
REQ-015 d_gnt  out  1  debug request accepted this cycle.
REQ-016 d_rvalid, d_rdata  out  1/DW  debug read return.
REQ-017 ram_en, ram_we, ram_addr, ram_wdata  out  1/1/AW/DW  single-port RAM command.
REQ-018 ram_rdata  in  DW  RAM read data, valid one cycle after ram_en with ram_we = 0.

Function
REQ-019 Grant is combinational in the request cycle: exactly one of p_gnt (= p_req & !p_stall) and d_gnt can be 1; the winner drives ram_* that cycle.
REQ-020 FSM states: IDLE, LAST_P, LAST_D, LOCK_D; state records the last winner for round-robin.
REQ-021 Single requester: granted immediately in any state except LOCK_D.
REQ-022 Both requesting, not locked: the port that did not win last is granted (IDLE treated as LAST_D, so the pipeline wins first).
REQ-023 A debug grant with d_lock = 1 moves the FSM to LOCK_D; in LOCK_D the debug port wins every cycle while d_req & d_lock.
REQ-024 LOCK_D exits to LAST_D when d_lock or d_req falls, or when hold_cnt reaches MAX_HOLD while p_req = 1; the pipeline then wins the next contended cycle.
REQ-025 hold_cnt increments on each locked debug grant with p_req = 1, clears on any pipeline grant or on leaving LOCK_D, and saturates at MAX_HOLD.
REQ-026 Granted read: rvalid is asserted to the issuing port exactly one cycle later, with rdata = ram_rdata; the other port's rvalid stays 0.
REQ-027 p_rdata and d_rdata hold their last value when rvalid = 0.
REQ-028 Granted write: ram_we = 1, and no rvalid is generated.
REQ-029 No requests: ram_en = 0, and the state remains unchanged.
REQ-030 Address and data pass through unmodified; no wrap or range checking, because AW bounds the address.

Reset
REQ-031 While reset = 0: FSM = IDLE, hold_cnt = 0, and rvalid tags are cleared.
REQ-032 While reset = 0: all outputs are 0, including p_stall, d_gnt, ram_en, both rvalid and both rdata.
REQ-033 A read granted in the cycle before reset asserts produces no rvalid after reset.
REQ-034 Requests are ignored during reset; arbitration resumes in the first cycle with reset = 1, from IDLE.

Verification
REQ-035 P-only traffic: p_req = 1, p_we = 0, p_addr = 5, RAM[5] = 0xDEADBEEF -> ram_en = 1, ram_addr = 5, p_stall = 0; next cycle p_rvalid = 1, p_rdata = 0xDEADBEEF.
REQ-036 Simultaneous requests from IDLE for 3 cycles -> winners are P, D, P; p_stall = 0, 1, 0; d_gnt = 0, 1, 0.
REQ-037 Locked starvation guard: d_req = d_lock = 1 and p_req = 1 held, MAX_HOLD = 4 -> 4 debug grants, then 1 pipeline grant, then the debug port re-locks.
REQ-038 Write then read: D writes 0x12345678 to address 31, then P reads address 31 -> p_rdata = 0x12345678 one cycle after the P grant, and d_rvalid never asserts.
REQ-039 Reset mid-read: P read granted, reset = 0 on the next edge -> p_rvalid = 0 and p_rdata = 0; after release, the FSM is in IDLE and P wins first contention.
REQ-040 Idle check: no requests for 10 cycles -> ram_en = 0 throughout and the FSM state is held.
